// File: rtl/dpram_arb_pkg.sv
// Shared constants and types for the dual-port RAM access controller.
// Consumers: arb2, dpram_arbiter (DPRAM_ARB_RR_EN selects round-robin arbitration).
package dpram_arb_pkg;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 4;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [0:0] client_id_t;

endpackage

// File: rtl/dpram_arbiter_arb2.sv
// Two-request arbiter with one-hot grant.
// DPRAM_ARB_RR_EN: round-robin via a last-grant pointer; otherwise fixed priority to client 0.
module arb2
  import dpram_arb_pkg::*;
(
`ifdef DPRAM_ARB_RR_EN
  input  logic       clk,
  input  logic       rst_n,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef DPRAM_ARB_RR_EN
  client_id_t last;

  // Reset value 1 makes client 0 the preferred winner of the first contest.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == 1'b1) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (|gnt) begin
      last <= gnt[1];
    end
  end
`else
  always_comb begin
    gnt    = '0;
    gnt[0] = req[0];
    gnt[1] = req[1] & ~req[0];
  end
`endif

endmodule

// File: rtl/dpram_arbiter.sv
// Two-client controller for a write-port-A / read-port-B RAM: zero-fills the RAM after reset,
// then arbitrates writes and reads independently. DPRAM_ARB_RR_EN selects round-robin arbitration.
module dpram_arbiter #(
  parameter int unsigned   AW       = dpram_arb_pkg::AW,
  parameter int unsigned   DW       = dpram_arb_pkg::DW,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c0_req,
  input  logic          c0_we,
  input  logic [AW-1:0] c0_addr,
  input  logic [DW-1:0] c0_wdata,
  output logic          c0_gnt,
  output logic          c0_rvalid,
  input  logic          c1_req,
  input  logic          c1_we,
  input  logic [AW-1:0] c1_addr,
  input  logic [DW-1:0] c1_wdata,
  output logic          c1_gnt,
  output logic          c1_rvalid,
  output logic [DW-1:0] rdata,
  output logic          init_done,
  output logic          ram_ena,
  output logic          ram_wea,
  output logic [AW-1:0] ram_addra,
  output logic [DW-1:0] ram_dia,
  output logic          ram_enb,
  output logic [AW-1:0] ram_addrb,
  input  logic [DW-1:0] ram_dob
);
  import dpram_arb_pkg::*;

  state_t        state;
  logic [AW-1:0] idx;
  logic          init_act;
  logic          run;
  logic [1:0]    wreq, rreq, wgnt, rgnt;
  logic [AW-1:0] addra_q, addrb_q;
  logic [DW-1:0] dia_q, rdata_q;
  logic          pend;
  client_id_t    rid;

  // Initialisation writes are gated by rst_n so the RAM pins show idle values while reset is held.
  assign init_act = rst_n && (state == INIT);
  assign run      = (state == RUN);

  assign wreq = run ? {c1_req & c1_we,  c0_req & c0_we}  : 2'b00;
  assign rreq = run ? {c1_req & ~c1_we, c0_req & ~c0_we} : 2'b00;

  arb2 u_warb (
`ifdef DPRAM_ARB_RR_EN
    .clk   (clk),
    .rst_n (rst_n),
`endif
    .req   (wreq),
    .gnt   (wgnt)
  );

  arb2 u_rarb (
`ifdef DPRAM_ARB_RR_EN
    .clk   (clk),
    .rst_n (rst_n),
`endif
    .req   (rreq),
    .gnt   (rgnt)
  );

  assign c0_gnt = wgnt[0] | rgnt[0];
  assign c1_gnt = wgnt[1] | rgnt[1];

  // Port A: init walker, then the write winner; idle keeps the last address/data.
  always_comb begin
    ram_ena   = init_act | (|wgnt);
    ram_wea   = init_act | (|wgnt);
    ram_addra = addra_q;
    ram_dia   = dia_q;
    if (init_act) begin
      ram_addra = idx;
      ram_dia   = INIT_VAL;
    end else if (wgnt[1]) begin
      ram_addra = c1_addr;
      ram_dia   = c1_wdata;
    end else if (wgnt[0]) begin
      ram_addra = c0_addr;
      ram_dia   = c0_wdata;
    end
  end

  always_comb begin
    ram_enb   = |rgnt;
    ram_addrb = addrb_q;
    if (rgnt[1]) begin
      ram_addrb = c1_addr;
    end else if (rgnt[0]) begin
      ram_addrb = c0_addr;
    end
  end

  assign c0_rvalid = pend & (rid == 1'b0);
  assign c1_rvalid = pend & (rid == 1'b1);
  assign rdata     = pend ? ram_dob : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      idx       <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          idx <= idx + 1'b1;
          if (idx == '1) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addra_q <= '0;
      dia_q   <= '0;
      addrb_q <= '0;
      rdata_q <= '0;
      pend    <= 1'b0;
      rid     <= 1'b0;
    end else begin
      addra_q <= ram_addra;
      dia_q   <= ram_dia;
      addrb_q <= ram_addrb;
      pend    <= |rgnt;
      rid     <= rgnt[1];
      if (pend) begin
        rdata_q <= ram_dob;
      end
    end
  end

endmodule
